dual_input_debouncer: RTL and testbench

- Two-channel synchroniser and debouncer for noisy asynchronous inputs, such as push-buttons or switches.
- Produces clean, glitch-free levels a and b that drive the inputs of the team's 2-input gate blocks (AND and similar) directly.
- Also provides one-cycle edge pulses per channel.
- Sits directly upstream of the gate stage. Both channels are independent and identical.

---
 rtl/dual_input_debouncer_pkg.sv | 7 +
 rtl/dual_input_debouncer_channel.sv | 38 +++
 rtl/dual_input_debouncer.sv | 28 ++
 tb/tb_dual_input_debouncer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/dual_input_debouncer_pkg.sv
// dual_input_debouncer_pkg: default sizing and per-channel state encoding for the debouncer
package dual_input_debouncer_pkg;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 1000;
    localparam logic STABLE = 1'b0;
    localparam logic COUNTING = 1'b1;
endpackage

// File: rtl/dual_input_debouncer_channel.sv
// debounce_channel: two-flop synchroniser and counter debouncer with registered edge pulses
module debounce_channel
    import dual_input_debouncer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic out,
    output logic rise,
    output logic fall
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic s1, s2, state, done;
    logic [CNT_W-1:0] cnt;
    assign state = (cnt == '0) ? STABLE : COUNTING;
    // the D-th consecutive mismatching sample commits the new level
    assign done = (s2 != out) && (cnt == LAST);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            cnt <= '0;
            out <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            cnt <= (s2 == out || done) ? '0 : (state == COUNTING) ? cnt + 1'b1 : CNT_W'(1);
            out <= done ? s2 : out;
            rise <= done & s2;
            fall <= done & ~s2;
        end
    end
endmodule

// File: rtl/dual_input_debouncer.sv
// dual_input_debouncer: two independent synchronise-and-debounce channels feeding the gate stage
module dual_input_debouncer
    import dual_input_debouncer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_param
        $error("DEBOUNCE_CYCLES must lie in 1..2^CNT_W-1");
    end
    debounce_channel #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_a (
        .clk(clk), .rst_n(rst_n), .raw(a_raw), .out(a), .rise(a_rise), .fall(a_fall)
    );
    debounce_channel #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_b (
        .clk(clk), .rst_n(rst_n), .raw(b_raw), .out(b), .rise(b_rise), .fall(b_fall)
    );
endmodule

// File: tb/tb_dual_input_debouncer.sv
// tb_dual_input_debouncer: scoreboard bench with an edge-history model of the debouncer (D=4)
module tb_dual_input_debouncer;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic a, b, a_rise, a_fall, b_rise, b_fall;
    int passed = 0, total = 0, edge_n = 0;
    logic [5:0] exp_q[$];
    logic ha[0:1023];
    logic hb[0:1023];
    logic ma = 1'b0, mb = 1'b0;
    int lfa = -100, lfb = -100;
    int a_rise_n = 0, a_fall_n = 0, b_rise_n = 0, b_fall_n = 0;
    int a_rise_edge = -1, a_fall_edge = -1, b_rise_edge = -1, b_fall_edge = -1;
    int k, j, m, n0, n1;

    dual_input_debouncer #(.CNT_W(3), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .a_raw(a_raw), .b_raw(b_raw),
        .a(a), .b(b), .a_rise(a_rise), .a_fall(a_fall), .b_rise(b_rise), .b_fall(b_fall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    endtask

    // level flips at edge n when the synchronised samples seen at the last D edges
    // (raw sampled at edges n-D-1..n-2) all differ from it and D edges passed since the last flip
    function automatic logic flips(input int n, input logic cur, input int lf, input logic ch_b);
        logic s;
        if (n - lf < D) return 1'b0;
        for (int i = n - D - 1; i <= n - 2; i++) begin
            s = (i < 1) ? 1'b0 : (ch_b ? hb[i] : ha[i]);
            if (s == cur) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        ma = 1'b0;
        mb = 1'b0;
        lfa = -100;
        lfb = -100;
    endtask

    task automatic step(input logic r, input logic ar, input logic br);
        logic fa, fb;
        logic [5:0] got;
        @(negedge clk);
        rst_n = r;
        a_raw = ar;
        b_raw = br;
        edge_n++;
        ha[edge_n] = r & ar;
        hb[edge_n] = r & br;
        if (!r) begin
            model_reset();
            exp_q.push_back(6'b0);
        end else begin
            fa = flips(edge_n, ma, lfa, 1'b0);
            fb = flips(edge_n, mb, lfb, 1'b1);
            exp_q.push_back({ma ^ fa, mb ^ fb, fa & ~ma, fa & ma, fb & ~mb, fb & mb});
            if (fa) begin ma = ~ma; lfa = edge_n; end
            if (fb) begin mb = ~mb; lfb = edge_n; end
        end
        @(posedge clk);
        #1;
        got = {a, b, a_rise, a_fall, b_rise, b_fall};
        if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
        else check("outputs", {26'd0, got}, {26'd0, exp_q.pop_front()});
        if (a_rise) begin a_rise_n++; a_rise_edge = edge_n; end
        if (a_fall) begin a_fall_n++; a_fall_edge = edge_n; end
        if (b_rise) begin b_rise_n++; b_rise_edge = edge_n; end
        if (b_fall) begin b_fall_n++; b_fall_edge = edge_n; end
    endtask

    initial begin
        #1;
        check("reset_state", {26'd0, a, b, a_rise, a_fall, b_rise, b_fall}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        k = edge_n + 1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);
        check("por_a_rise_edge", a_rise_edge, k + 5);
        check("por_b_rise_edge", b_rise_edge, k + 5);
        check("por_rise_count", a_rise_n + b_rise_n, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {26'd0, a, b, a_rise, a_fall, b_rise, b_fall}, 32'd0);
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
        n0 = a_fall_n;
        n1 = b_rise_n + b_fall_n;
        k = edge_n + 1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        check("clean_rise_edge", a_rise_edge, k + 5);
        check("clean_no_fall", a_fall_n, n0);
        check("clean_b_quiet", b_rise_n + b_fall_n, n1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
        n0 = a_rise_n;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
        check("glitch_no_rise", a_rise_n, n0);
        check("glitch_level", {31'd0, a}, 32'd0);
        check("glitch_cnt", {29'd0, dut.u_a.cnt}, 32'd0);
        n0 = a_rise_n;
        for (int i = 0; i < 8; i++) step(1'b1, i[1] ? 1'b0 : 1'b1, 1'b0);
        j = edge_n + 1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        check("bounce_rise_count", a_rise_n - n0, 1);
        check("bounce_rise_edge", a_rise_edge, j + 5);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);
        check("sim_pre_levels", {30'd0, a, b}, 32'd3);
        k = edge_n + 1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
        check("sim_a_fall_edge", a_fall_edge, k + 5);
        check("sim_b_fall_edge", b_fall_edge, k + 5);
        check("sim_levels", {30'd0, a, b}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midcount_reset", {26'd0, a, b, a_rise, a_fall, b_rise, b_fall}, 32'd0);
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        m = edge_n + 1;
        n0 = a_rise_n;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        check("midcount_rise_edge", a_rise_edge, m + 5);
        check("midcount_rise_count", a_rise_n - n0, 1);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
